// File: rtl/dmem_pkg.sv
// dmem_sized shared types and constants.
// Access sizes, FSM states and latency bound.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_BAD = 2'b11
  } size_e;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int LAT_MAX = 4;

endpackage

// File: rtl/dmem_lane_fmt.sv
// Byte-lane formatter for dmem_sized.
// Builds store masks/data and extends loads.
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_uns,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_mask,
  output logic [31:0] o_wdata,
  output logic        o_misalign,
  output logic [31:0] o_rdata
);

  size_e       w_size;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_size = size_e'(i_size);
  assign w_byte = 8'(i_rword >> {i_lane, 3'b000});
  assign w_half = 16'(i_rword >> {i_lane[1], 4'b0000});

  // Store side: lane mask, replicated data, alignment check
  always_comb begin
    o_mask     = 4'b0000;
    o_wdata    = i_wdata;
    o_misalign = 1'b0;
    unique case (w_size)
      SZ_B: begin
        o_mask  = 4'b0001 << i_lane;
        o_wdata = {4{i_wdata[7:0]}};
      end
      SZ_H: begin
        o_mask     = i_lane[1] ? 4'b1100 : 4'b0011;
        o_wdata    = {2{i_wdata[15:0]}};
        o_misalign = i_lane[0];
      end
      SZ_W: begin
        o_mask     = 4'b1111;
        o_wdata    = i_wdata;
        o_misalign = (i_lane != 2'b00);
      end
      default: begin
        o_mask  = 4'b0000;
        o_wdata = i_wdata;
      end
    endcase
  end

  // Load side: extract addressed bytes and extend
  always_comb begin
    o_rdata = i_rword;
    unique case (w_size)
      SZ_B: o_rdata = i_uns ? {24'h0, w_byte}
                            : {{24{w_byte[7]}}, w_byte};
      SZ_H: o_rdata = i_uns ? {16'h0, w_half}
                            : {{16{w_half[15]}}, w_half};
      SZ_W: o_rdata = i_rword;
      default: o_rdata = i_rword;
    endcase
  end

endmodule

// File: rtl/dmem_sized.sv
// Sized data memory with init sweep and
// fixed-latency in-order responses.
module dmem_sized
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 1,
  parameter logic [31:0] FILL        = 32'h0000_0000,
  parameter logic [31:0] ERR_DATA    = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_e        r_state;
  state_e        w_state_nx;
  logic [AW-1:0] r_cnt;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic [LATENCY-1:0] r_vld;
  logic [LATENCY-1:0] r_err;
  logic [31:0]        r_dat [LATENCY];

  logic          w_acc;
  logic          w_last;
  logic [AW-1:0] w_idx;
  logic [1:0]    w_lane;
  logic          w_bad;
  logic          w_mis;
  logic          w_oor;
  logic          w_err;
  logic [3:0]    w_mask;
  logic [31:0]   w_wdat;
  logic [31:0]   w_ldat;
  logic [31:0]   w_rword;

  assign w_idx   = req_addr[2 +: AW];
  assign w_lane  = req_addr[1:0];
  assign w_rword = r_mem[w_idx];
  assign w_bad   = (req_size == SZ_BAD);
  assign w_oor   = ({2'b00, req_addr[31:2]}
                    >= 32'(DEPTH_WORDS));
  assign w_err   = w_bad | w_mis | w_oor;
  assign w_acc   = req_valid & req_ready & ~rst;
  assign w_last  = (r_cnt == AW'(DEPTH_WORDS - 1));

  dmem_lane_fmt u_fmt (
    .i_size     (req_size),
    .i_uns      (req_unsigned),
    .i_lane     (w_lane),
    .i_wdata    (req_wdata),
    .i_rword    (w_rword),
    .o_mask     (w_mask),
    .o_wdata    (w_wdat),
    .o_misalign (w_mis),
    .o_rdata    (w_ldat)
  );

  // State register and init sweep counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      if (r_state == INIT)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    w_state_nx = r_state;
    req_ready  = 1'b0;
    busy       = 1'b1;
    unique case (r_state)
      INIT: begin
        if (w_last)
          w_state_nx = RUN;
      end
      RUN: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      default: w_state_nx = INIT;
    endcase
  end

  // Storage: fill during init, masked stores in run
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == INIT) begin
        r_mem[r_cnt] <= FILL;
      end else if (w_acc && req_we && !w_err) begin
        for (int b = 0; b < 4; b++)
          if (w_mask[b])
            r_mem[w_idx][8*b +: 8] <= w_wdat[8*b +: 8];
      end
    end
  end

  // Response pipe: stage 0 captures the read, rest delay
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      r_err <= '0;
      for (int i = 0; i < LATENCY; i++)
        r_dat[i] <= ERR_DATA;
    end else begin
      r_vld[0] <= w_acc;
      r_err[0] <= w_acc & w_err;
      if (!w_acc || w_err)
        r_dat[0] <= ERR_DATA;
      else if (req_we)
        r_dat[0] <= 32'h0;
      else
        r_dat[0] <= w_ldat;
      for (int i = 1; i < LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_err[i] <= r_err[i-1];
        r_dat[i] <= r_dat[i-1];
      end
    end
  end

  assign rsp_valid = r_vld[LATENCY-1];
  assign rsp_err   = r_err[LATENCY-1];
  assign rsp_rdata = r_dat[LATENCY-1];

endmodule
